// File: rtl/round_robin_arbiter.sv
// Purpose : registered one-hot round-robin arbiter; rotation resumes above the most recent winner.
// Latency : 1 cycle from requests to grant/grant_valid/grant_changed; no combinational request->output path.
// Backpressure: none; requests are level-sensitive and held by the requester until served.
// Option  : define ROUND_ROBIN_ARBITER_HOLD_EN to let the current owner keep the grant while its request stays high.
module round_robin_arbiter #(
  parameter int WORD_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] requests,
  output logic [WORD_WIDTH-1:0] grant,
  output logic                  grant_valid,
  output logic                  grant_changed
);

  localparam logic [WORD_WIDTH-1:0] ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH-1:0] ONES = {WORD_WIDTH{1'b1}};

  logic [WORD_WIDTH-1:0] grant_q, grant_d;
  logic                  valid_q, valid_d;
  logic                  changed_q, changed_d;
  // Most recent non-zero grant; survives idle cycles so rotation picks up where it left off.
  logic [WORD_WIDTH-1:0] last_q, last_d;

  logic [WORD_WIDTH-1:0] therm_mask;
  logic [WORD_WIDTH-1:0] higher_mask;
  logic [WORD_WIDTH-1:0] masked_req;
  logic [WORD_WIDTH-1:0] masked_low;
  logic [WORD_WIDTH-1:0] req_low;
  logic [WORD_WIDTH-1:0] next_grant;

  // Priority mask: every bit strictly above the last winner, or everything when there is no history.
  always_comb begin
    therm_mask  = ~(last_q - ONE);
    higher_mask = therm_mask & ~last_q;
    if (last_q == '0) begin
      therm_mask  = ONES;
      higher_mask = ONES;
    end
  end

  // Lowest-set-bit isolation (x & -x, two's complement at WORD_WIDTH bits) for both candidate sets.
  always_comb begin
    masked_req = requests & higher_mask;
    masked_low = masked_req & (~masked_req + ONE);
    req_low    = requests & (~requests + ONE);
  end

  // Next-grant selection: nearest requester above the last winner, else wrap to the lowest requester.
  always_comb begin
    next_grant = '0;
    if (masked_req != '0) begin
      next_grant = masked_low;
    end else if (requests != '0) begin
      next_grant = req_low;
    end
`ifdef ROUND_ROBIN_ARBITER_HOLD_EN
    // Burst/lock: an owner whose request is still up keeps the resource.
    if ((grant_q != '0) && ((requests & grant_q) != '0)) begin
      next_grant = grant_q;
    end
`endif
  end

  // Next-state values for the output registers and the history register.
  always_comb begin
    grant_d   = next_grant;
    valid_d   = (next_grant != '0);
    changed_d = (next_grant != '0) && (next_grant != grant_q);
    last_d    = last_q;
    // Tracking next rather than grant_q keeps last equal to the live grant whenever one is held.
    if (next_grant != '0) begin
      last_d = next_grant;
    end
  end

  // State registers with synchronous active-high reset taking precedence over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      last_q    <= '0;
    end else begin
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      last_q    <= last_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_changed = changed_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with WORD_WIDTH=4.
// Inputs change #1 after a rising edge; outputs are checked #1 after the following rising edge.
module tb_round_robin_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] requests;
  logic [3:0] grant;
  logic       grant_valid;
  logic       grant_changed;

  int n_checks;
  int n_pass;

  round_robin_arbiter #(.WORD_WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .requests     (requests),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_changed(grant_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // One clock, then check all three outputs.
  task automatic step_chk(input string tag, input logic [3:0] g, input logic v, input logic c);
    step();
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, v});
    chk({tag, ".changed"}, {7'b0, grant_changed}, {7'b0, c});
  endtask

  initial begin
    logic [3:0] rot [8];
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    requests = 4'b1111;

    // Reset dominates even with every request raised.
    for (int i = 0; i < 3; i++) step_chk("reset", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;

`ifndef ROUND_ROBIN_ARBITER_HOLD_EN
    // Full contention: strict rotation, a change pulse every cycle.
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) step_chk($sformatf("rot%0d", i), rot[i], 1'b1, 1'b1);

    // Sole requester: re-granted, change pulse only first time; MSB history forces wrap path.
    requests = 4'b0100;
    step_chk("sole0", 4'b0100, 1'b1, 1'b1);
    step_chk("sole1", 4'b0100, 1'b1, 1'b0);
    step_chk("sole2", 4'b0100, 1'b1, 1'b0);
    requests = 4'b0000;
    step_chk("idle", 4'b0000, 1'b0, 1'b0);

    // Make 1000 the last winner, idle 5 cycles, then 1001 must wrap to 0001 then 1000.
    requests = 4'b1000;
    step_chk("msb", 4'b1000, 1'b1, 1'b1);
    requests = 4'b0000;
    for (int i = 0; i < 5; i++) step_chk($sformatf("gap%0d", i), 4'b0000, 1'b0, 1'b0);
    requests = 4'b1001;
    step_chk("wrap", 4'b0001, 1'b1, 1'b1);
    step_chk("wrap_next", 4'b1000, 1'b1, 1'b1);

    // last=0010, requests=1010: skip to 1000, then back to 0010.
    requests = 4'b0010;
    step_chk("set0010", 4'b0010, 1'b1, 1'b1);
    requests = 4'b1010;
    step_chk("skip", 4'b1000, 1'b1, 1'b1);
    step_chk("skip_back", 4'b0010, 1'b1, 1'b1);

    // Withdrawal while granted moves to the remaining requester, then to idle.
    requests = 4'b0100;
    step_chk("withdraw", 4'b0100, 1'b1, 1'b1);
    requests = 4'b0000;
    step_chk("withdraw_idle", 4'b0000, 1'b0, 1'b0);

    // Reset mid-grant drops the grant at once and clears history.
    requests = 4'b1111;
    step_chk("pre_rst", 4'b1000, 1'b1, 1'b1);
    reset = 1'b1;
    step_chk("mid_rst", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    step_chk("post_rst", 4'b0001, 1'b1, 1'b1);
`else
    // Hold mode: owner keeps the grant while its request stays up.
    requests = 4'b0011;
    step_chk("hold0", 4'b0001, 1'b1, 1'b1);
    step_chk("hold1", 4'b0001, 1'b1, 1'b0);
    step_chk("hold2", 4'b0001, 1'b1, 1'b0);
    step_chk("hold3", 4'b0001, 1'b1, 1'b0);
    requests = 4'b0010;
    step_chk("release", 4'b0010, 1'b1, 1'b1);
    requests = 4'b1010;
    step_chk("hold_other", 4'b0010, 1'b1, 1'b0);
    requests = 4'b1000;
    step_chk("release2", 4'b1000, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
